// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and types used by the fetch front end and the
// decoder.
package cpu_pkg;

   localparam int CPU_ADDR_WIDTH = 32;
   localparam int CPU_INST_WIDTH = 32;

   localparam logic [CPU_ADDR_WIDTH-1:0] CPU_RESET_PC = 32'h0000_0000;
   localparam logic [CPU_INST_WIDTH-1:0] NOP_INST     = 32'h0000_0013;

   typedef struct packed {
      logic [CPU_INST_WIDTH-1:0] inst;
      logic [CPU_ADDR_WIDTH-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bundle: instruction memory request/response, redirect input
// and the decode-facing instruction stream.
interface fetch_unit_if
   import cpu_pkg::*;
#(
   parameter int ADDR_WIDTH = CPU_ADDR_WIDTH,
   parameter int INST_WIDTH = CPU_INST_WIDTH
) ();

   logic                  imem_req_valid;
   logic                  imem_req_ready;
   logic [ADDR_WIDTH-1:0] imem_req_addr;
   logic                  imem_resp_valid;
   logic [INST_WIDTH-1:0] imem_resp_data;
   logic                  redirect_valid;
   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic                  stall;
   logic [INST_WIDTH-1:0] instruction;
   logic                  inst_valid;
   logic [ADDR_WIDTH-1:0] inst_pc;

   // Fetch unit side.
   modport master (
      output imem_req_valid, imem_req_addr, instruction, inst_valid, inst_pc,
      input  imem_req_ready, imem_resp_valid, imem_resp_data,
             redirect_valid, redirect_pc, stall
   );

   // Memory / decode / branch-resolution side.
   modport slave (
      input  imem_req_valid, imem_req_addr, instruction, inst_valid, inst_pc,
      output imem_req_ready, imem_resp_valid, imem_resp_data,
             redirect_valid, redirect_pc, stall
   );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush; the head entry is read straight from
// register storage so consumers see no path from the write side.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = fetch_entry_t,
   localparam int PTR_W   = $clog2(DEPTH),
   localparam int CNT_W   = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  entry_t           push_data,
   input  logic             pop,
   input  logic             flush,
   output entry_t           head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   entry_t           mem_reg [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CNT_W'(DEPTH));
   assign count   = count_reg;
   assign head    = mem_reg[rd_ptr_reg];
   assign do_pop  = pop && !empty;
   // A push into a full queue is legal only when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_reg[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
         assert (!(push && full && !do_pop));
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited sequential fetch, in-order
// response queue, and redirect with stale-response dropping.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = CPU_ADDR_WIDTH,
   parameter int                    INST_WIDTH  = CPU_INST_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = CPU_RESET_PC,
   parameter int                    QUEUE_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master bus
);

   localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

   typedef logic [ADDR_WIDTH-1:0] pc_t;

   pc_t              fetch_pc_reg;
   pc_t              fetch_pc_next;
   logic [CNT_W-1:0] outstanding_reg;
   logic [CNT_W-1:0] outstanding_next;
   logic [CNT_W-1:0] drop_cnt_reg;
   logic [CNT_W-1:0] drop_cnt_next;

   logic [CNT_W-1:0] inst_count;
   logic [CNT_W-1:0] tag_count;
   logic             inst_full;
   logic             inst_empty;
   logic             tag_full;
   logic             tag_empty;
   fetch_entry_t     inst_head;
   fetch_entry_t     inst_push_data;
   pc_t              tag_head;

   logic [CNT_W:0]   credit_used;
   logic             req_valid;
   logic             accept;
   logic             resp_drop;
   logic             resp_keep;
   logic             inst_pop;
   logic [INST_WIDTH-1:0] head_inst;
   pc_t              head_pc;

   // Every request either sits in the queue or is still in flight, so this
   // sum bounds how many responses could ever need a queue slot.
   assign credit_used = {1'b0, inst_count} + {1'b0, outstanding_reg};
   assign req_valid   = !rst && !bus.redirect_valid &&
                        (credit_used < (CNT_W+1)'(QUEUE_DEPTH));
   assign accept      = req_valid && bus.imem_req_ready;

   // The response landing in a redirect cycle belongs to the old path too.
   assign resp_drop   = bus.imem_resp_valid &&
                        ((drop_cnt_reg != '0) || bus.redirect_valid);
   assign resp_keep   = bus.imem_resp_valid && !resp_drop;
   assign inst_pop    = !inst_empty && !bus.stall && !bus.redirect_valid;

   assign inst_push_data.inst = bus.imem_resp_data;
   assign inst_push_data.pc   = tag_head;

   always_comb begin
      outstanding_next = outstanding_reg + CNT_W'(accept)
                         - CNT_W'(bus.imem_resp_valid);
      fetch_pc_next    = fetch_pc_reg;
      drop_cnt_next    = drop_cnt_reg;
      if (bus.redirect_valid) begin
         fetch_pc_next = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
         drop_cnt_next = outstanding_next;
      end else begin
         if (accept) begin
            fetch_pc_next = fetch_pc_reg + ADDR_WIDTH'(4);
         end
         if (bus.imem_resp_valid && (drop_cnt_reg != '0)) begin
            drop_cnt_next = drop_cnt_reg - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_reg    <= RESET_PC;
         outstanding_reg <= '0;
         drop_cnt_reg    <= '0;
      end else begin
         fetch_pc_reg    <= fetch_pc_next;
         outstanding_reg <= outstanding_next;
         drop_cnt_reg    <= drop_cnt_next;
         assert (!(bus.imem_resp_valid && (outstanding_reg == '0)));
         assert (!(resp_keep && tag_empty));
         assert (!(accept && tag_full));
         assert (!(resp_keep && inst_full && !inst_pop));
         assert (credit_used <= (CNT_W+1)'(QUEUE_DEPTH));
         // Live tags plus responses still to be discarded account for every request in flight.
         assert (tag_count + drop_cnt_reg == outstanding_reg);
      end
   end

   fetch_queue #(
      .DEPTH   (QUEUE_DEPTH),
      .entry_t (fetch_entry_t)
   ) u_inst_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (resp_keep),
      .push_data (inst_push_data),
      .pop       (inst_pop),
      .flush     (bus.redirect_valid),
      .head      (inst_head),
      .count     (inst_count),
      .full      (inst_full),
      .empty     (inst_empty)
   );

   fetch_queue #(
      .DEPTH   (QUEUE_DEPTH),
      .entry_t (pc_t)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (accept),
      .push_data (fetch_pc_reg),
      .pop       (resp_keep),
      .flush     (bus.redirect_valid),
      .head      (tag_head),
      .count     (tag_count),
      .full      (tag_full),
      .empty     (tag_empty)
   );

   assign head_inst = inst_head.inst;
   assign head_pc   = inst_head.pc;

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = fetch_pc_reg;
   assign bus.inst_valid     = !inst_empty;
   assign bus.instruction    = inst_empty ? '0 : head_inst;
   assign bus.inst_pc        = inst_empty ? '0 : head_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: behavioural memory, a PC-stream reference
// model feeding an expectation queue, and a monitor that checks each pop.
module tb_fetch_unit;
   import cpu_pkg::*;

   localparam int          QD       = 4;
   localparam logic [31:0] RST_PC   = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fetch_unit_if bus ();

   fetch_unit #(
      .ADDR_WIDTH  (32),
      .INST_WIDTH  (32),
      .RESET_PC    (RST_PC),
      .QUEUE_DEPTH (QD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
   typedef struct { logic [31:0] addr; int due; bit stale; } pend_t;

   exp_t  exp_q  [$];
   pend_t pend_q [$];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int ready_pct = 100, stall_pct = 0, redir_pct = 0, rst_pm = 0;
   int lat_lo = 1, lat_hi = 1;
   int rst_left = 2;
   bit redir_req = 0;
   logic [31:0] redir_target = '0;

   logic [31:0] exp_fetch_pc = RST_PC;
   int last_due = 0;
   int first_acc_cyc = -1, first_valid_cyc = -1;
   bit acc_armed = 0, pop_armed = 0;
   logic [31:0] acc_after_redir = '1, pop_after_redir = '1;
   int pop_count = 0;

   int n_checks = 0, n_pass = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      n_checks++;
      if (actual === expected) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                    name, actual, expected, cyc);
   endtask

   // Driver: memory model, random/directed stimulus, request-side checks.
   initial begin : driver
      int stale_now, lat, due;
      bit redir, exp_req, prev_wait;
      logic [31:0] tgt, prev_addr;
      prev_wait = 0;
      prev_addr = '0;
      bus.imem_req_ready  = 1'b0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_pc     = '0;
      bus.stall           = 1'b0;
      forever begin
         @(negedge clk);
         rst = (rst_left > 0) ||
               (rst_pm > 0 && int'($urandom_range(999, 0)) < rst_pm);
         if (rst_left > 0) rst_left--;
         bus.imem_req_ready = int'($urandom_range(99, 0)) < ready_pct;
         bus.stall          = int'($urandom_range(99, 0)) < stall_pct;
         redir     = 0;
         stale_now = 0;
         if (rst) begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = $urandom;
            bus.redirect_valid  = 1'b0;
            bus.redirect_pc     = $urandom;
            exp_q.delete();
            pend_q.delete();
            exp_fetch_pc    = RST_PC;
            last_due        = 0;
            first_acc_cyc   = -1;
            first_valid_cyc = -1;
            acc_armed       = 0;
            pop_armed       = 0;
         end else begin
            foreach (pend_q[i]) if (pend_q[i].stale) stale_now++;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
               bus.imem_resp_valid = 1'b1;
               bus.imem_resp_data  = mem_word(pend_q[0].addr);
               void'(pend_q.pop_front());
            end else begin
               bus.imem_resp_valid = 1'b0;
               bus.imem_resp_data  = $urandom;
            end
            redir = redir_req || (int'($urandom_range(99, 0)) < redir_pct);
            if (redir_req) begin
               tgt       = redir_target;
               redir_req = 0;
            end else begin
               tgt = $urandom;
            end
            bus.redirect_valid = redir;
            bus.redirect_pc    = tgt;
            if (redir) begin
               exp_q.delete();
               foreach (pend_q[i]) pend_q[i].stale = 1;
               exp_fetch_pc = {tgt[31:2], 2'b00};
               acc_armed    = 1;
               pop_armed    = 1;
            end
         end
         #1;
         exp_req = !rst && !redir && (exp_q.size() + stale_now < QD);
         check("req_valid", {31'd0, bus.imem_req_valid}, {31'd0, exp_req});
         if (prev_wait && bus.imem_req_valid)
            check("addr_hold", bus.imem_req_addr, prev_addr);
         if (bus.imem_req_valid && bus.imem_req_ready) begin
            check("req_addr", bus.imem_req_addr, exp_fetch_pc);
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            if (acc_armed) begin
               acc_after_redir = bus.imem_req_addr;
               acc_armed       = 0;
            end
            lat = int'($urandom_range(lat_hi, lat_lo));
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_q.push_back('{addr: bus.imem_req_addr, due: due, stale: 1'b0});
            exp_q.push_back('{pc: exp_fetch_pc, inst: mem_word(exp_fetch_pc)});
            exp_fetch_pc += 32'd4;
         end
         prev_wait = bus.imem_req_valid && !bus.imem_req_ready;
         prev_addr = bus.imem_req_addr;
      end
   end

   // Monitor: pops expectations whenever the decoder consumes an instruction.
   initial begin : monitor
      bit prev_rst, prev_redir, prev_hold;
      logic [31:0] prev_inst, prev_pc;
      exp_t e;
      prev_rst = 0; prev_redir = 0; prev_hold = 0;
      prev_inst = '0; prev_pc = '0;
      forever begin
         @(negedge clk);
         #2;
         if (prev_rst) begin
            check("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
            check("rst_instruction", bus.instruction, 32'd0);
            check("rst_inst_pc", bus.inst_pc, 32'd0);
         end else if (prev_redir) begin
            check("redir_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
         end else if (prev_hold) begin
            check("stall_valid", {31'd0, bus.inst_valid}, 32'd1);
            check("stall_inst", bus.instruction, prev_inst);
            check("stall_pc", bus.inst_pc, prev_pc);
         end
         if (!rst && bus.inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (!rst && bus.inst_valid && !bus.stall && !bus.redirect_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("pop_pc", bus.inst_pc, e.pc);
               check("pop_inst", bus.instruction, e.inst);
               pop_count++;
               if (pop_armed) begin
                  pop_after_redir = bus.inst_pc;
                  pop_armed       = 0;
               end
               $display("pop pc=%08h inst=%08h cycle=%0d", bus.inst_pc, bus.instruction, cyc);
            end
         end
         prev_rst   = rst;
         prev_redir = bus.redirect_valid && !rst;
         prev_hold  = !rst && bus.inst_valid && bus.stall && !bus.redirect_valid;
         prev_inst  = bus.instruction;
         prev_pc    = bus.inst_pc;
      end
   end

   // Control: sequences directed scenarios, then a randomised soak and a drain.
   initial begin : control
      int snap;
      repeat (20) @(posedge clk);
      check("first_latency", first_valid_cyc - first_acc_cyc, 32'd2);
      snap = pop_count;
      repeat (8) @(posedge clk);
      check("throughput", pop_count - snap, 32'd8);

      stall_pct = 100;
      repeat (6) @(posedge clk);
      @(negedge clk); #3;
      check("stall_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
      check("stall_inst_valid", {31'd0, bus.inst_valid}, 32'd1);
      @(posedge clk);
      stall_pct = 0;
      repeat (10) @(posedge clk);

      lat_lo = 3; lat_hi = 3;
      repeat (10) @(posedge clk);
      acc_after_redir = '1;
      pop_after_redir = '1;
      redir_target = 32'h0000_0103;
      redir_req = 1;
      repeat (15) @(posedge clk);
      check("redir_acc_addr", acc_after_redir, 32'h0000_0100);
      check("redir_pop_pc", pop_after_redir, 32'h0000_0100);

      lat_lo = 1; lat_hi = 1;
      repeat (6) @(posedge clk);
      redir_target = 32'h0000_0200;
      redir_req = 1;
      repeat (8) @(posedge clk);

      ready_pct = 0;
      repeat (4) @(posedge clk);
      ready_pct = 100;
      repeat (8) @(posedge clk);

      lat_lo = 2; lat_hi = 2; stall_pct = 100;
      repeat (6) @(posedge clk);
      rst_left = 1;
      repeat (2) @(posedge clk);
      stall_pct = 0;
      repeat (10) @(posedge clk);

      redir_target = 32'hFFFF_FFF9;
      redir_req = 1;
      repeat (12) @(posedge clk);

      lat_lo = 1; lat_hi = 3; ready_pct = 70; stall_pct = 30;
      redir_pct = 3; rst_pm = 2;
      repeat (3000) @(posedge clk);

      redir_pct = 0; rst_pm = 0; stall_pct = 0; ready_pct = 0;
      for (int i = 0; i < 60 && (exp_q.size() > 0 || pend_q.size() > 0); i++)
         @(posedge clk);
      repeat (2) @(posedge clk);
      check("drain_left", exp_q.size(), 32'd0);
      @(negedge clk); #3;
      check("drain_inst_valid", {31'd0, bus.inst_valid}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
